// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. Ages are carried at the widest supported width (8 ways -> 3 bits).
package icache_pkg;

    localparam int MAX_WAYS  = 8;
    localparam int MAX_AGE_W = 3;

    typedef enum logic [1:0] {FLUSH, IDLE, LOOKUP, REFILL} state_t;

    typedef logic [MAX_WAYS-1:0][MAX_AGE_W-1:0] age_vec_t;

    // Lowest-index invalid way wins; otherwise the oldest valid way (age == ways-1).
    function automatic logic [MAX_AGE_W-1:0] victim_sel(input logic [MAX_WAYS-1:0] valid,
                                                        input age_vec_t ages, input int ways);
        logic [MAX_AGE_W-1:0] v;
        logic found;
        v     = '0;
        found = 1'b0;
        for (int i = MAX_WAYS-1; i >= 0; i--) begin
            if (i < ways && !valid[i]) begin
                v     = MAX_AGE_W'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < MAX_WAYS; i++) begin
                if (i < ways && int'(ages[i]) == ways-1) v = MAX_AGE_W'(i);
            end
        end
        return v;
    endfunction

    // True-LRU update. An invalid way being filled counts as "older than everything",
    // so all valid ways age by one and the ages of valid ways stay a permutation.
    function automatic age_vec_t lru_update(input age_vec_t ages, input logic [MAX_WAYS-1:0] valid,
                                            input logic [MAX_AGE_W-1:0] way, input int ways);
        age_vec_t n;
        int old;
        n   = ages;
        old = valid[way] ? int'(ages[way]) : ways;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (i < ways && valid[i] && int'(ages[i]) < old) n[i] = ages[i] + 3'd1;
        end
        n[way] = '0;
        return n;
    endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
// Latency: n/a (wires only). Ports: read_en/read_addr/ready/fetch_valid/RDATA_OUT/cache_miss,
// mem_req/mem_addr/fetch/write_data. Backpressure: ready (fetch side), mem_req held until fetch.
interface icache_nway_if #(parameter int ADDR_W = 20);
    logic              read_en;
    logic [ADDR_W-1:0] read_addr;
    logic              ready;
    logic              fetch_valid;
    logic [31:0]       RDATA_OUT;
    logic              cache_miss;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              fetch;
    logic [31:0]       write_data;

    modport master (output read_en, read_addr, fetch, write_data,
                    input  ready, fetch_valid, RDATA_OUT, cache_miss, mem_req, mem_addr);
    modport slave  (input  read_en, read_addr, fetch, write_data,
                    output ready, fetch_valid, RDATA_OUT, cache_miss, mem_req, mem_addr);
endinterface

// File: rtl/icache_way.sv
// One cache way: tag-entry array plus data array, one write port and one synchronous read port.
// Latency: 1 cycle read; a read of the index being written returns the new value (write-first).
// Backpressure: none. Ports: i_clk, i_tag_we/i_dat_we, i_wr_idx/i_wr_ent/i_wr_dat, i_rd_idx, o_rd_ent/o_rd_dat.
module icache_way #(
    parameter int SETS  = 256,
    parameter int IDX_W = 8,
    parameter int ENT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_tag_we,
    input  logic             i_dat_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [ENT_W-1:0] i_wr_ent,
    input  logic [31:0]      i_wr_dat,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [ENT_W-1:0] o_rd_ent,
    output logic [31:0]      o_rd_dat
);
    logic [ENT_W-1:0] r_ent_mem [SETS];
    logic [31:0]      r_dat_mem [SETS];

    // Write-first forwarding keeps LRU ages coherent when a hit updates a set
    // in the same cycle that the next request to that set is being read.
    always_ff @(posedge i_clk) begin
        if (i_tag_we) r_ent_mem[i_wr_idx] <= i_wr_ent;
        if (i_dat_we) r_dat_mem[i_wr_idx] <= i_wr_dat;
        o_rd_ent <= (i_tag_we && i_wr_idx == i_rd_idx) ? i_wr_ent : r_ent_mem[i_rd_idx];
        o_rd_dat <= (i_dat_we && i_wr_idx == i_rd_idx) ? i_wr_dat : r_dat_mem[i_rd_idx];
    end
endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with refill handshake, flush sweep and true-LRU.
// Latency: hit data 1 cycle after accept, 1/cycle throughput; miss -> mem_req 2 cycles after accept.
// Backpressure: ready low during flush/miss/refill; mem_req held until fetch. ICACHE_STATS_EN adds hit_count/miss_count.
module icache_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 256,
    parameter int ADDR_W = 20
) (
    input  logic           CLK,
    input  logic           resetn,
    icache_nway_if.slave   bus,
    input  logic           flush,
    output logic           flush_busy
`ifdef ICACHE_STATS_EN
    , output logic [31:0]  hit_count
    , output logic [31:0]  miss_count
`endif
);
    import icache_pkg::*;

    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [AGE_W-1:0] age;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_cnt;
    logic [ADDR_W-1:2]   r_addr;
    logic                r_flush_pend;
    logic                w_accept, w_hit, w_fetch, w_tag_we, w_unused;
    tag_entry_t          w_rd_ent [WAYS];
    tag_entry_t          w_wr_ent [WAYS];
    logic [31:0]         w_rd_dat [WAYS];
    logic [WAYS-1:0]     w_dat_we;
    logic [IDX_W-1:0]    w_rd_idx, w_wr_idx;
    logic [MAX_WAYS-1:0] w_valid, w_match;
    age_vec_t            w_ages, w_new_ages;
    logic [2:0]          w_hit_way, w_victim, w_acc_way;
    logic [31:0]         w_hit_dat;

    assign w_unused = ^bus.read_addr[1:0];   // byte offset within the word is irrelevant

    assign w_accept = bus.read_en & bus.ready;
    assign w_fetch  = (r_state == REFILL) & bus.fetch;

    always_comb begin
        w_valid   = '0;
        w_ages    = '0;
        w_match   = '0;
        w_hit_way = '0;
        w_hit_dat = '0;
        for (int j = 0; j < WAYS; j++) begin
            w_valid[j] = w_rd_ent[j].valid;
            w_ages[j]  = MAX_AGE_W'(w_rd_ent[j].age);
            w_match[j] = w_rd_ent[j].valid && (w_rd_ent[j].tag == r_addr[ADDR_W-1:IDX_W+2]);
            if (w_match[j]) begin
                w_hit_way = 3'(j);
                w_hit_dat = w_rd_dat[j];
            end
        end
    end

    assign w_hit      = (r_state == LOOKUP) && (|w_match);
    assign w_victim   = victim_sel(w_valid, w_ages, WAYS);
    assign w_acc_way  = (r_state == REFILL) ? w_victim : w_hit_way;
    assign w_new_ages = lru_update(w_ages, w_valid, w_acc_way, WAYS);

    // All ways of the set are rewritten on hit/refill so the age vector stays consistent.
    assign w_tag_we = (r_state == FLUSH) | w_hit | w_fetch;
    assign w_wr_idx = (r_state == FLUSH) ? r_cnt : r_addr[IDX_W+1:2];
    assign w_rd_idx = w_accept ? bus.read_addr[IDX_W+1:2] : r_addr[IDX_W+1:2];

    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            w_dat_we[j]       = 1'b0;
            w_wr_ent[j].valid = w_rd_ent[j].valid;
            w_wr_ent[j].age   = AGE_W'(w_new_ages[j]);
            w_wr_ent[j].tag   = w_rd_ent[j].tag;
            if (r_state == FLUSH) begin
                w_wr_ent[j] = '0;
            end else if (r_state == REFILL && w_victim == 3'(j)) begin
                w_wr_ent[j].valid = 1'b1;
                w_wr_ent[j].age   = '0;
                w_wr_ent[j].tag   = r_addr[ADDR_W-1:IDX_W+2];
                w_dat_we[j]       = w_fetch;
            end
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_way #(.SETS(SETS), .IDX_W(IDX_W), .ENT_W($bits(tag_entry_t))) u_way (
            .i_clk    (CLK),
            .i_tag_we (w_tag_we),
            .i_dat_we (w_dat_we[g]),
            .i_wr_idx (w_wr_idx),
            .i_wr_ent (w_wr_ent[g]),
            .i_wr_dat (bus.write_data),
            .i_rd_idx (w_rd_idx),
            .o_rd_ent (w_rd_ent[g]),
            .o_rd_dat (w_rd_dat[g])
        );
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= FLUSH;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= (r_state == FLUSH) ? r_cnt + 1'b1 : '0;
            if (w_accept) r_addr <= bus.read_addr[ADDR_W-1:2];
            // A flush seen mid-refill is parked until the refill data arrives.
            r_flush_pend <= (r_state == REFILL) && !bus.fetch && (r_flush_pend || flush);
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.ready       = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.RDATA_OUT   = '0;
        bus.cache_miss  = 1'b0;
        bus.mem_req     = 1'b0;
        case (r_state)
            FLUSH: if (r_cnt == IDX_W'(SETS-1)) w_next = IDLE;
            IDLE: begin
                bus.ready = !flush;
                if (flush)            w_next = FLUSH;
                else if (bus.read_en) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (w_hit) begin
                    bus.fetch_valid = 1'b1;
                    bus.RDATA_OUT   = w_hit_dat;
                    bus.ready       = !flush;
                    if (flush)            w_next = FLUSH;
                    else if (bus.read_en) w_next = LOOKUP;
                    else                  w_next = IDLE;
                end else begin
                    bus.cache_miss = 1'b1;
                    w_next         = flush ? FLUSH : REFILL;
                end
            end
            REFILL: begin
                bus.mem_req    = 1'b1;
                bus.cache_miss = 1'b1;
                if (bus.fetch) begin
                    bus.fetch_valid = 1'b1;
                    bus.RDATA_OUT   = bus.write_data;
                    w_next          = (flush || r_flush_pend) ? FLUSH : IDLE;
                end
            end
            default: w_next = FLUSH;
        endcase
    end

    assign bus.mem_addr = {r_addr, 2'b00};
    assign flush_busy   = (r_state == FLUSH);

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_hit)                          hit_count  <= hit_count + 32'd1;
            if (r_state == LOOKUP && !w_hit)    miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;
    localparam int WAYS = 4, SETS = 256, ADDR_W = 20, IDX_W = 8;

    logic CLK = 1'b0, resetn = 1'b0, flush = 1'b0, flush_busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_nway_if #(.ADDR_W(ADDR_W)) bus();

    icache_nway #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .bus        (bus),
        .flush      (flush),
        .flush_busy (flush_busy)
`ifdef ICACHE_STATS_EN
        , .hit_count  (hit_count)
        , .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    int mtag [SETS][WAYS];   // per set, tags in recency order (index 0 = most recent)
    int mcnt [SETS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = {a[ADDR_W-1:2], 2'b00};
        if (w == 20'h00400) return 32'h0000_0013;
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [ADDR_W-1:0] mk(input int tag, input int idx);
        return ADDR_W'((tag << (IDX_W+2)) | (idx << 2));
    endfunction

    task automatic mdl_clear();
        for (int s = 0; s < SETS; s++) mcnt[s] = 0;
    endtask

    // LRU list per set: hit moves the tag to the front; miss inserts at the front and drops the oldest.
    task automatic mdl_access(input logic [ADDR_W-1:0] a, output bit hit);
        int idx, tag, p;
        idx = int'(a[IDX_W+1:2]);
        tag = int'(a[ADDR_W-1:IDX_W+2]);
        p   = -1;
        for (int i = 0; i < mcnt[idx]; i++) if (mtag[idx][i] == tag) p = i;
        hit = (p >= 0);
        if (!hit) begin
            if (mcnt[idx] < WAYS) mcnt[idx]++;
            p = mcnt[idx] - 1;
        end
        for (int i = p; i > 0; i--) mtag[idx][i] = mtag[idx][i-1];
        mtag[idx][0] = tag;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_flush(input string tag);
        int n;
        n = 0;
        while (flush_busy && n < 2000) begin
            n++;
            tick();
        end
        chk(tag, n, SETS);
        chk("ready_after_flush", bus.ready, 1);
        mdl_clear();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input bit flush_mid);
        int n;
        bit exp_hit;
        logic [ADDR_W-1:0] wa;
        n = 0;
        while (!bus.ready && n < 100) begin
            n++;
            tick();
        end
        chk("ready_wait", bus.ready, 1);
        mdl_access(a, exp_hit);
        bus.read_en   = 1'b1;
        bus.read_addr = a;
        @(posedge CLK);
        #2;
        bus.read_en = 1'b0;
        #1;
        chk("cache_miss", bus.cache_miss, 32'(!exp_hit));
        chk("fetch_valid", bus.fetch_valid, 32'(exp_hit));
        if (exp_hit) begin
            chk("hit_data", bus.RDATA_OUT, mem_word(a));
            chk("hit_ready", bus.ready, 1);
        end else begin
            chk("miss_ready", bus.ready, 0);
            tick();
            wa = {a[ADDR_W-1:2], 2'b00};
            chk("mem_req", bus.mem_req, 1);
            chk("mem_addr", 32'(bus.mem_addr), 32'(wa));
            if (flush_mid) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                #1;
                chk("req_hold_flush", bus.mem_req, 1);
            end
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("req_hold", bus.mem_req, 1);
            end
            bus.fetch      = 1'b1;
            bus.write_data = mem_word(wa);
            #1;
            chk("refill_valid", bus.fetch_valid, 1);
            chk("refill_data", bus.RDATA_OUT, mem_word(a));
            tick();
            bus.fetch = 1'b0;
            #1;
            if (flush_mid) wait_flush("flush_after_refill");
            else           chk("ready_after_refill", bus.ready, 1);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        time t0;
        int lru_seq [10] = '{0, 1, 2, 3, 0, 4, 0, 2, 3, 4};
        bus.read_en = 1'b0; bus.read_addr = '0; bus.fetch = 1'b0; bus.write_data = '0;
        mdl_clear();
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_ready", bus.ready, 0);
        chk("rst_fetch_valid", bus.fetch_valid, 0);
        chk("rst_cache_miss", bus.cache_miss, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_rdata", bus.RDATA_OUT, 0);
        chk("rst_flush_busy", flush_busy, 1);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
`endif
        resetn = 1'b1;
        wait_flush("reset_flush_len");

        // cold miss then re-read hit
        do_read(20'h00400, 1'b0);
        do_read(20'h00400, 1'b0);

        // back-to-back hits, one per cycle
        do_read(20'h00404, 1'b0);
        do_read(20'h00408, 1'b0);
        t0 = $time;
        do_read(20'h00400, 1'b0);
        do_read(20'h00404, 1'b0);
        do_read(20'h00408, 1'b0);
        chk("b2b_time", 32'($time - t0), 30);

        // LRU at index 5: tag 1 must be the one evicted by tag 4
        for (int i = 0; i < 10; i++) do_read(mk(lru_seq[i], 5), 1'b0);
        chk("lru_tag1_gone", bus.cache_miss, 0);
        do_read(mk(1, 5), 1'b0);

        // randomized conflict-heavy traffic
        repeat (150) begin
            a = mk(int'($urandom_range(0, 5)), int'($urandom_range(0, 2))) | ADDR_W'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tick();
            do_read(a, 1'b0);
        end

        // flush wins over a simultaneous request in IDLE
        while (!bus.ready) tick();
        tick();
        flush = 1'b1; bus.read_en = 1'b1; bus.read_addr = 20'h00400;
        #1;
        chk("flush_blocks_ready", bus.ready, 0);
        tick();
        flush = 1'b0; bus.read_en = 1'b0;
        chk("flush_busy_idle", flush_busy, 1);
        wait_flush("idle_flush_len");
        do_read(20'h00400, 1'b0);

        // flush during refill: refill first, then sweep, then address misses again
        do_read(mk(9, 20), 1'b1);
        do_read(mk(9, 20), 1'b0);

        // reset in the middle of a refill
        bus.read_en = 1'b1; bus.read_addr = mk(3, 7);
        tick();
        bus.read_en = 1'b0;
        tick();
        chk("pre_rst_mem_req", bus.mem_req, 1);
        resetn = 1'b0;
        #1;
        chk("rst_drops_mem_req", bus.mem_req, 0);
        chk("rst_flush_busy2", flush_busy, 1);
        tick();
        resetn = 1'b1;
        wait_flush("reset_mid_flush_len");

        // 3 misses then 5 hits
        do_read(mk(7, 10), 1'b0);
        do_read(mk(8, 10), 1'b0);
        do_read(mk(9, 10), 1'b0);
        do_read(mk(7, 10), 1'b0);
        do_read(mk(8, 10), 1'b0);
        do_read(mk(9, 10), 1'b0);
        do_read(mk(7, 10), 1'b0);
        do_read(mk(8, 10), 1'b0);
        tick();
`ifdef ICACHE_STATS_EN
        chk("miss_count", miss_count, 3);
        chk("hit_count", hit_count, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
